// File: rtl/ufm_data_writer_if.sv
// ---------------------------------------------------------------------------
// ufm_data_writer_if
// Bundles the three bus groups used by the UFM data writer:
//   - input word stream   : in_valid, in_data, in_last, in_ready
//   - flash data port     : data_addr, data_write, data_writedata,
//                           data_waitrequest, data_read, data_readdata,
//                           data_readdatavalid
//   - CSR status access   : stat_read, stat_readdata
// Modports:
//   master - the writer block (drives requests, in_ready)
//   slave  - the environment (word source, flash data port, CSR)
// ---------------------------------------------------------------------------
interface ufm_data_writer_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_last;
    logic              in_ready;

    logic [ADDR_W-1:0] data_addr;
    logic              data_write;
    logic [31:0]       data_writedata;
    logic              data_waitrequest;
    logic              data_read;
    logic [31:0]       data_readdata;
    logic              data_readdatavalid;

    logic              stat_read;
    logic [31:0]       stat_readdata;

    modport master (
        input  in_valid, in_data, in_last,
        output in_ready,
        output data_addr, data_write, data_writedata, data_read,
        input  data_waitrequest, data_readdata, data_readdatavalid,
        output stat_read,
        input  stat_readdata
    );

    modport slave (
        output in_valid, in_data, in_last,
        input  in_ready,
        input  data_addr, data_write, data_writedata, data_read,
        output data_waitrequest, data_readdata, data_readdatavalid,
        input  stat_read,
        output stat_readdata
    );
endinterface

// File: rtl/ufm_data_writer.sv
// ---------------------------------------------------------------------------
// ufm_data_writer
// Programs a stream of 32-bit words into the on-chip flash data port once the
// CSR erase sequencer reports idle flash. After each write the CSR status
// register is polled until the write-successful bit appears, the flash stops
// reporting busy, or the poll budget runs out.
//
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   erase_done      erase sequencer idle; dropping it mid-run is an error
//   start           one-cycle request to (re)start programming
//   bus             ufm_data_writer_if.master (stream, data port, CSR status)
//   busy            high outside IDLE / DONE / ERROR
//   done, error     sticky completion / failure flags
//   words_written   count of words successfully programmed
//
// Build option: define UFM_WRITER_VERIFY_EN to read back every word after a
// successful status check and compare it with the written value.
// ---------------------------------------------------------------------------
module ufm_data_writer #(
    parameter int                ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = 12'h3FF,
    parameter int                POLL_LIMIT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  erase_done,
    input  logic                  start,
    ufm_data_writer_if.master     bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_W:0]       words_written
);

    localparam int POLL_W = $clog2(POLL_LIMIT + 1) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_IN, S_WRITE, S_STAT_RD, S_STAT_CHK, S_NEXT, S_DONE, S_ERROR
`ifdef UFM_WRITER_VERIFY_EN
        , S_VERIFY_RD, S_VERIFY_WAIT
`endif
    } state_t;

`ifdef UFM_WRITER_VERIFY_EN
    localparam state_t STAT_OK_STATE = S_VERIFY_RD;
`else
    localparam state_t STAT_OK_STATE = S_NEXT;
`endif

    state_t              state_reg, state_next;
    // One bit wider than the port address so END_ADDR+1 is visible as overflow.
    logic [ADDR_W:0]     addr_reg;
    logic [31:0]         data_reg;
    logic                last_reg;
    logic [POLL_W-1:0]   poll_reg;
    logic [POLL_W-1:0]   poll_next;
    logic [ADDR_W:0]     words_reg;
    logic                done_reg;
    logic                error_reg;
    logic                unused_bits;

    assign poll_next = poll_reg + 1'b1;

`ifdef UFM_WRITER_VERIFY_EN
    assign unused_bits = ^{bus.stat_readdata[31:4], bus.stat_readdata[2]};
`else
    assign unused_bits = ^{bus.stat_readdata[31:4], bus.stat_readdata[2],
                           bus.data_readdata, bus.data_readdatavalid};
`endif

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            addr_reg  <= {1'b0, START_ADDR};
            data_reg  <= '0;
            last_reg  <= 1'b0;
            poll_reg  <= '0;
            words_reg <= '0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;

            // Fresh run from any resting state
            if (state_next == S_WAIT_IN &&
                (state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_ERROR)) begin
                addr_reg  <= {1'b0, START_ADDR};
                words_reg <= '0;
                done_reg  <= 1'b0;
                error_reg <= 1'b0;
            end

            if (state_reg == S_WAIT_IN && bus.in_valid) begin
                data_reg <= bus.in_data;
                last_reg <= bus.in_last;
            end

            if (state_next == S_WRITE && state_reg != S_WRITE)
                poll_reg <= '0;
            else if (state_reg == S_STAT_CHK)
                poll_reg <= poll_next;

            if (state_reg == S_NEXT) begin
                words_reg <= words_reg + 1'b1;
                addr_reg  <= addr_reg + 1'b1;
            end

            if (state_reg == S_NEXT && state_next == S_DONE)
                done_reg <= 1'b1;

            if (state_next == S_ERROR && state_reg != S_ERROR)
                error_reg <= 1'b1;
        end
    end

    // Next-state logic. Losing erase_done aborts at the next state boundary,
    // so a stalled write or read request is never dropped mid-handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start && erase_done)
                    state_next = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                if (!erase_done)
                    state_next = S_ERROR;
                else if (bus.in_valid)
                    state_next = (addr_reg > {1'b0, END_ADDR}) ? S_ERROR : S_WRITE;
            end
            S_WRITE: begin
                if (!bus.data_waitrequest)
                    state_next = erase_done ? S_STAT_RD : S_ERROR;
            end
            S_STAT_RD: begin
                state_next = erase_done ? S_STAT_CHK : S_ERROR;
            end
            S_STAT_CHK: begin
                if (!erase_done)
                    state_next = S_ERROR;
                else if (bus.stat_readdata[1:0] == 2'b00)
                    state_next = bus.stat_readdata[3] ? STAT_OK_STATE : S_ERROR;
                else if (poll_next >= POLL_W'(POLL_LIMIT))
                    state_next = S_ERROR;
                else
                    state_next = S_STAT_RD;
            end
`ifdef UFM_WRITER_VERIFY_EN
            S_VERIFY_RD: begin
                if (!bus.data_waitrequest)
                    state_next = erase_done ? S_VERIFY_WAIT : S_ERROR;
            end
            S_VERIFY_WAIT: begin
                if (!erase_done)
                    state_next = S_ERROR;
                else if (bus.data_readdatavalid)
                    state_next = (bus.data_readdata == data_reg) ? S_NEXT : S_ERROR;
            end
`endif
            S_NEXT: begin
                if (!erase_done)
                    state_next = S_ERROR;
                else
                    state_next = last_reg ? S_DONE : S_WAIT_IN;
            end
            S_DONE, S_ERROR: begin
                if (start && erase_done)
                    state_next = S_WAIT_IN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; all zero in IDLE, which reset enters.
    always_comb begin
        bus.in_ready       = 1'b0;
        bus.data_write     = 1'b0;
        bus.data_addr      = '0;
        bus.data_writedata = '0;
        bus.data_read      = 1'b0;
        bus.stat_read      = 1'b0;
        busy               = 1'b1;
        case (state_reg)
            S_IDLE, S_DONE, S_ERROR: busy = 1'b0;
            S_WAIT_IN:  bus.in_ready = 1'b1;
            S_WRITE: begin
                bus.data_write     = 1'b1;
                bus.data_addr      = addr_reg[ADDR_W-1:0];
                bus.data_writedata = data_reg;
            end
            S_STAT_RD:  bus.stat_read = 1'b1;
`ifdef UFM_WRITER_VERIFY_EN
            S_VERIFY_RD: begin
                bus.data_read = 1'b1;
                bus.data_addr = addr_reg[ADDR_W-1:0];
            end
`endif
            default: ;
        endcase
    end

    assign done          = done_reg;
    assign error         = error_reg;
    assign words_written = words_reg;

endmodule

// File: tb/tb_ufm_data_writer.sv
// ---------------------------------------------------------------------------
// tb_ufm_data_writer
// Two writer instances: u_dut (START_ADDR 0) and u_dut_hi (START_ADDR =
// END_ADDR = 0x3FF) for the address overflow case. Accepted writes on u_dut
// are captured into obs_q and compared against exp_q entries pushed when
// stimulus is driven.
// ---------------------------------------------------------------------------
module tb_ufm_data_writer;

`ifdef UFM_WRITER_VERIFY_EN
    localparam int EXP_GAP = 7;
`else
    localparam int EXP_GAP = 4;
`endif

    logic        clk, rst, erase_done, start0, start1;
    logic        busy0, done0, error0, busy1, done1, error1;
    logic [12:0] words0, words1;

    int tests_run = 0;
    int fails     = 0;

    ufm_data_writer_if #(.ADDR_W(12)) bus0 ();
    ufm_data_writer_if #(.ADDR_W(12)) bus1 ();

    ufm_data_writer #(.ADDR_W(12), .START_ADDR(12'h000), .END_ADDR(12'h3FF), .POLL_LIMIT(255)) u_dut (
        .clk(clk), .rst(rst), .erase_done(erase_done), .start(start0), .bus(bus0),
        .busy(busy0), .done(done0), .error(error0), .words_written(words0));

    ufm_data_writer #(.ADDR_W(12), .START_ADDR(12'h3FF), .END_ADDR(12'h3FF), .POLL_LIMIT(255)) u_dut_hi (
        .clk(clk), .rst(rst), .erase_done(erase_done), .start(start1), .bus(bus1),
        .busy(busy1), .done(done1), .error(error1), .words_written(words1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment models (update on falling edge) ----------
    logic [43:0] exp_q[$];
    logic [43:0] obs_q[$];
    logic [31:0] stat_q[$];
    int          stall_left = 0;
    int          stall_seen = 0;
    bit          prev_stall = 0;
    bit          unstable   = 0;
    logic [11:0] prev_addr;
    logic [31:0] prev_data;
    int          wr_cnt = 0;
    int          stat_cnt = 0;
    logic [31:0] last_wdata = '0;
    int          rd_delay = 0;
    bit          rd_corrupt = 0;
    logic [31:0] rd_value = '0;
    bit          rd1_pend = 0;
    int          wr1_cnt = 0;
    logic [11:0] wr1_addr = '0;
    logic [31:0] wr1_data = '0;

    always @(negedge clk) begin
        if (bus0.data_write && stall_left > 0) begin
            bus0.data_waitrequest = 1'b1;
            stall_left--;
        end else begin
            bus0.data_waitrequest = 1'b0;
        end
        if (prev_stall && (!bus0.data_write || bus0.data_addr !== prev_addr ||
                           bus0.data_writedata !== prev_data))
            unstable = 1'b1;
        if (bus0.data_write && bus0.data_waitrequest) begin
            stall_seen++;
            prev_stall = 1'b1;
            prev_addr  = bus0.data_addr;
            prev_data  = bus0.data_writedata;
        end else begin
            prev_stall = 1'b0;
        end
        if (bus0.data_write && !bus0.data_waitrequest) begin
            obs_q.push_back({bus0.data_addr, bus0.data_writedata});
            wr_cnt++;
            last_wdata = bus0.data_writedata;
        end
        if (bus0.stat_read) begin
            stat_cnt++;
            bus0.stat_readdata = (stat_q.size() > 0) ? stat_q.pop_front() : 32'h0000_0008;
        end
        // readback with two cycles of latency
        bus0.data_readdatavalid = 1'b0;
        if (rd_delay != 0) begin
            rd_delay--;
            if (rd_delay == 0) begin
                bus0.data_readdatavalid = 1'b1;
                bus0.data_readdata      = rd_value;
            end
        end
        if (bus0.data_read && !bus0.data_waitrequest) begin
            rd_delay = 2;
            rd_value = rd_corrupt ? last_wdata + 32'd1 : last_wdata;
        end
    end

    always @(negedge clk) begin
        bus1.data_readdatavalid = rd1_pend;
        rd1_pend                = bus1.data_read;
        bus1.data_readdata      = wr1_data;
        bus1.stat_readdata      = 32'h0000_0008;
        if (bus1.data_write) begin
            wr1_cnt++;
            wr1_addr = bus1.data_addr;
            wr1_data = bus1.data_writedata;
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
        tick();
        exp_q.delete(); obs_q.delete(); stat_q.delete();
        stall_left = 0; stall_seen = 0; prev_stall = 0; unstable = 0;
        wr_cnt = 0; stat_cnt = 0; rd_corrupt = 0;
        wr1_cnt = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        tick();
        start0 = 1'b0; start1 = 1'b0;
    endtask

    // Offers one word; waited = cycles spent before in_ready was seen.
    task automatic send_word(input bit sel, input logic [31:0] d, input logic l,
                             output int waited, output bit ok);
        waited = 0; ok = 1'b0;
        if (sel) begin bus1.in_valid = 1'b1; bus1.in_data = d; bus1.in_last = l; end
        else     begin bus0.in_valid = 1'b1; bus0.in_data = d; bus0.in_last = l; end
        for (int i = 0; i < 200; i++) begin
            if (sel ? bus1.in_ready : bus0.in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
            waited++;
        end
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
    endtask

    task automatic wait_term(input bit sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (sel ? (done1 | error1) : (done0 | error0)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- tests ----------------------------------------------
    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({bus0.in_ready, bus0.data_write, bus0.data_read, bus0.stat_read} !== 4'b0000) begin
            fails++; $display("FAIL reset_strobes got=%b want=0000",
                {bus0.in_ready, bus0.data_write, bus0.data_read, bus0.stat_read});
        end
        tests_run++;
        if ({busy0, done0, error0} !== 3'b000) begin
            fails++; $display("FAIL reset_flags got=%b want=000", {busy0, done0, error0});
        end
        tests_run++;
        if (words0 !== 13'd0 || bus0.data_addr !== 12'd0 || bus0.data_writedata !== 32'd0) begin
            fails++; $display("FAIL reset_values words=%0d addr=%h wdata=%h want 0/000/00000000",
                words0, bus0.data_addr, bus0.data_writedata);
        end
        $display("[TB] reset: busy=%0b done=%0b error=%0b words=%0d", busy0, done0, error0, words0);
    endtask

    task automatic test_basic();
        logic [31:0] img[3];
        logic [43:0] e, o;
        int  waited;
        bit  ok;
        img[0] = 32'hA5A5_A5A5; img[1] = 32'h1234_5678; img[2] = 32'hDEAD_BEEF;
        do_reset();
        erase_done = 1'b1;
        pulse_start(1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({12'(i), img[i]});
            send_word(1'b0, img[i], (i == 2), waited, ok);
            tests_run++;
            if (!ok) begin fails++; $display("FAIL basic_handshake word=%0d got=timeout want=accept", i); end
            if (i == 1) begin
                tests_run++;
                if (waited != EXP_GAP) begin
                    fails++; $display("FAIL basic_word_gap got=%0d want=%0d", waited, EXP_GAP);
                end
            end
        end
        wait_term(1'b0, ok);
        tests_run++;
        if (!ok) begin fails++; $display("FAIL basic_terminate got=timeout want=done"); end
        tests_run++;
        if ({done0, error0, busy0} !== 3'b100 || words0 !== 13'd3) begin
            fails++; $display("FAIL basic_status done=%0b error=%0b busy=%0b words=%0d want 1/0/0/3",
                done0, error0, busy0, words0);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL basic_write_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                fails++; $display("FAIL basic_write got=%h:%h want=%h:%h", o[43:32], o[31:0], e[43:32], e[31:0]);
            end
            $display("[TB] write addr=%h data=%h", o[43:32], o[31:0]);
        end
    endtask

    task automatic test_start_no_erase();
        do_reset();
        erase_done = 1'b0;
        pulse_start(1'b0);
        bus0.in_valid = 1'b1; bus0.in_data = 32'h1111_1111; bus0.in_last = 1'b1;
        repeat (5) tick();
        bus0.in_valid = 1'b0;
        tests_run++;
        if ({busy0, bus0.in_ready, error0} !== 3'b000 || wr_cnt != 0) begin
            fails++; $display("FAIL no_erase busy=%0b in_ready=%0b error=%0b writes=%0d want 0/0/0/0",
                busy0, bus0.in_ready, error0, wr_cnt);
        end
        $display("[TB] start without erase_done: busy=%0b writes=%0d", busy0, wr_cnt);
    endtask

    task automatic test_erase_drop();
        do_reset();
        erase_done = 1'b1;
        pulse_start(1'b0);
        erase_done = 1'b0;
        tick();
        tests_run++;
        if ({error0, busy0, done0} !== 3'b100) begin
            fails++; $display("FAIL erase_drop error=%0b busy=%0b done=%0b want 1/0/0", error0, busy0, done0);
        end
        $display("[TB] erase_done dropped in WAIT_IN: error=%0b", error0);
    endtask

    task automatic test_waitrequest();
        logic [43:0] o;
        int  waited;
        bit  ok;
        do_reset();
        erase_done = 1'b1;
        stall_left = 4;
        pulse_start(1'b0);
        exp_q.push_back({12'h000, 32'hCAFE_0001});
        send_word(1'b0, 32'hCAFE_0001, 1'b1, waited, ok);
        wait_term(1'b0, ok);
        tests_run++;
        if (stall_seen != 4 || unstable) begin
            fails++; $display("FAIL stall_hold stalled=%0d unstable=%0b want 4/0", stall_seen, unstable);
        end
        tests_run++;
        if (obs_q.size() != 1 || done0 !== 1'b1) begin
            fails++; $display("FAIL stall_single_write writes=%0d done=%0b want 1/1", obs_q.size(), done0);
        end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            tests_run++;
            if (o !== exp_q[0]) begin
                fails++; $display("FAIL stall_write got=%h want=%h", o, exp_q[0]);
            end
        end
        $display("[TB] waitrequest x4: stalled=%0d done=%0b", stall_seen, done0);
    endtask

    task automatic test_status_poll();
        int waited;
        bit ok;
        do_reset();
        erase_done = 1'b1;
        stat_q.push_back(32'h2); stat_q.push_back(32'h2); stat_q.push_back(32'h8);
        pulse_start(1'b0);
        send_word(1'b0, 32'h0BAD_F00D, 1'b1, waited, ok);
        wait_term(1'b0, ok);
        tests_run++;
        if (stat_cnt != 3 || done0 !== 1'b1 || error0 !== 1'b0 || words0 !== 13'd1) begin
            fails++; $display("FAIL poll_busy polls=%0d done=%0b error=%0b words=%0d want 3/1/0/1",
                stat_cnt, done0, error0, words0);
        end
        $display("[TB] status busy,busy,ok: polls=%0d done=%0b", stat_cnt, done0);

        do_reset();
        stat_q.push_back(32'h0);
        pulse_start(1'b0);
        send_word(1'b0, 32'h0BAD_F00D, 1'b1, waited, ok);
        wait_term(1'b0, ok);
        tests_run++;
        if (error0 !== 1'b1 || done0 !== 1'b0 || words0 !== 13'd0) begin
            fails++; $display("FAIL poll_fail error=%0b done=%0b words=%0d want 1/0/0", error0, done0, words0);
        end
        $display("[TB] status 0x00: error=%0b words=%0d", error0, words0);
    endtask

    task automatic test_addr_overflow();
        int waited;
        bit ok;
        do_reset();
        erase_done = 1'b1;
        pulse_start(1'b1);
        send_word(1'b1, 32'h5555_AAAA, 1'b0, waited, ok);
        send_word(1'b1, 32'h6666_BBBB, 1'b1, waited, ok);
        tests_run++;
        if (!ok) begin fails++; $display("FAIL overflow_handshake got=timeout want=accept"); end
        tick(); tick();
        tests_run++;
        if (error1 !== 1'b1 || done1 !== 1'b0 || words1 !== 13'd1) begin
            fails++; $display("FAIL overflow_flags error=%0b done=%0b words=%0d want 1/0/1", error1, done1, words1);
        end
        tests_run++;
        if (wr1_cnt != 1 || wr1_addr !== 12'h3FF) begin
            fails++; $display("FAIL overflow_writes count=%0d addr=%h want 1/3ff", wr1_cnt, wr1_addr);
        end
        $display("[TB] overflow: writes=%0d last_addr=%h error=%0b", wr1_cnt, wr1_addr, error1);
    endtask

    task automatic test_reset_mid_write();
        int waited;
        bit ok;
        do_reset();
        erase_done = 1'b1;
        stall_left = 10;
        pulse_start(1'b0);
        send_word(1'b0, 32'h7777_1234, 1'b1, waited, ok);
        tests_run++;
        if (bus0.data_write !== 1'b1 || bus0.data_writedata !== 32'h7777_1234) begin
            fails++; $display("FAIL midwrite_active write=%0b wdata=%h want 1/77771234",
                bus0.data_write, bus0.data_writedata);
        end
        rst = 1'b1;
        tick();
        stall_left = 0;
        tests_run++;
        if ({bus0.data_write, bus0.in_ready, bus0.stat_read, busy0, done0, error0} !== 6'b0 ||
            bus0.data_writedata !== 32'd0 || bus0.data_addr !== 12'd0 || words0 !== 13'd0) begin
            fails++; $display("FAIL midwrite_reset write=%0b busy=%0b wdata=%h addr=%h words=%0d want all 0",
                bus0.data_write, busy0, bus0.data_writedata, bus0.data_addr, words0);
        end
        rst = 1'b0;
        tick();
        $display("[TB] reset mid-write: write=%0b busy=%0b", bus0.data_write, busy0);
    endtask

`ifdef UFM_WRITER_VERIFY_EN
    task automatic test_verify();
        int waited;
        bit ok;
        do_reset();
        erase_done = 1'b1;
        rd_corrupt = 1'b1;
        pulse_start(1'b0);
        send_word(1'b0, 32'h1234_5678, 1'b1, waited, ok);
        wait_term(1'b0, ok);
        tests_run++;
        if (error0 !== 1'b1 || done0 !== 1'b0) begin
            fails++; $display("FAIL verify_mismatch error=%0b done=%0b want 1/0", error0, done0);
        end
        $display("[TB] verify mismatch: error=%0b", error0);

        do_reset();
        pulse_start(1'b0);
        send_word(1'b0, 32'h1234_5678, 1'b1, waited, ok);
        wait_term(1'b0, ok);
        tests_run++;
        if (done0 !== 1'b1 || error0 !== 1'b0 || words0 !== 13'd1) begin
            fails++; $display("FAIL verify_match done=%0b error=%0b words=%0d want 1/0/1", done0, error0, words0);
        end
        $display("[TB] verify match: done=%0b", done0);
    endtask
`endif

    initial begin
        rst = 1'b1; erase_done = 1'b0; start0 = 1'b0; start1 = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_last = 1'b0;
        bus0.data_waitrequest = 1'b0; bus0.data_readdata = '0;
        bus0.data_readdatavalid = 1'b0; bus0.stat_readdata = '0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_last = 1'b0;
        bus1.data_waitrequest = 1'b0; bus1.data_readdata = '0;
        bus1.data_readdatavalid = 1'b0; bus1.stat_readdata = '0;

        test_reset();
        test_basic();
        test_start_no_erase();
        test_erase_drop();
        test_waitrequest();
        test_status_poll();
        test_addr_overflow();
        test_reset_mid_write();
`ifdef UFM_WRITER_VERIFY_EN
        test_verify();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
